// File: rtl/tpu_pkg.sv
// Shared TPU definitions: elementwise function codes, the sequencer FSM
// state type, and a reference helper for the elementwise datapath.
package tpu_pkg;

    // Elementwise function codes; any code other than PASS/RELU zeroes the data.
    localparam logic [3:0] FUNC_NONE = 4'b0000;
    localparam logic [3:0] FUNC_PASS = 4'b0001;
    localparam logic [3:0] FUNC_RELU = 4'b0010;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Behaviour of the elementwise unit for one signed element.
    function automatic logic signed [31:0] ew_apply(input logic [3:0] func,
                                                    input logic signed [31:0] x);
        logic signed [31:0] y;
        case (func)
            FUNC_PASS: y = x;
            FUNC_RELU: y = (x < 0) ? 32'sd0 : x;
            default:   y = 32'sd0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/ewu_sequencer_if.sv
// Command channel into the elementwise sequencer: a valid/ready handshake
// carrying function code, source/destination base addresses and length.
interface ewu_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_func;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;

    // Command producer side.
    modport master (
        output cmd_valid,
        output cmd_func,
        output cmd_src,
        output cmd_dst,
        output cmd_len,
        input  cmd_ready
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid,
        input  cmd_func,
        input  cmd_src,
        input  cmd_dst,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/ewu_sequencer.sv
// Elementwise-unit sequencer: accepts one command at a time, streams
// len reads from the accumulator buffer, drives the elementwise unit one
// cycle later and the output-buffer writes one cycle after that.
module ewu_sequencer
    import tpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    ewu_sequencer_if.slave    cmd,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              ew_en,
    output logic [3:0]        ew_func,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    // Control state and latched command fields.
    seq_state_t        state_reg;
    logic              cmd_ready_reg;
    logic              done_reg;
    logic [3:0]        func_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issued_reg;   // reads issued so far, counts 1..len
    logic              drain_cnt_reg;

    // Stage 0: read issue, with the matching destination address carried along.
    logic              rd_en_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [ADDR_W-1:0] dst_addr_reg;

    // Stage 1: elementwise unit drive.
    logic              ew_en_reg;
    logic [3:0]        ew_func_reg;
    logic [ADDR_W-1:0] ew_addr_reg;

    // Stage 2: destination write.
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;

    logic handshake;

    // Ready is registered so it stays low while reset is held.
    assign handshake = cmd.cmd_valid && cmd_ready_reg;

    // Command FSM: latch on handshake, issue one read per cycle, wait for the
    // pipeline to drain, then pulse done for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b0;
            done_reg      <= 1'b0;
            func_reg      <= FUNC_NONE;
            len_reg       <= '0;
            issued_reg    <= '0;
            drain_cnt_reg <= 1'b0;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            dst_addr_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
                        cmd_ready_reg <= 1'b0;
                        func_reg      <= cmd.cmd_func;
                        len_reg       <= cmd.cmd_len;
                        rd_addr_reg   <= cmd.cmd_src;
                        dst_addr_reg  <= cmd.cmd_dst;
                        if (cmd.cmd_len == '0) begin
                            // Empty run: skip straight to completion.
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            // First read goes out in the cycle after the handshake.
                            state_reg  <= ST_ISSUE;
                            rd_en_reg  <= 1'b1;
                            issued_reg <= LEN_W'(1);
                        end
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issued_reg == len_reg) begin
                        // Last read is out; let the two pipeline stages empty.
                        state_reg     <= ST_DRAIN;
                        rd_en_reg     <= 1'b0;
                        drain_cnt_reg <= 1'b0;
                    end else begin
                        rd_addr_reg  <= rd_addr_reg + ADDR_W'(1);
                        dst_addr_reg <= dst_addr_reg + ADDR_W'(1);
                        issued_reg   <= issued_reg + LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Second drain cycle carries the final write.
                    if (drain_cnt_reg) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_cnt_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b0;
                    rd_en_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage valid/address delay line from read issue to destination write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ew_en_reg   <= 1'b0;
            ew_func_reg <= FUNC_NONE;
            ew_addr_reg <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
        end else begin
            ew_en_reg   <= rd_en_reg;
            ew_func_reg <= rd_en_reg ? func_reg : FUNC_NONE;
            if (rd_en_reg) begin
                ew_addr_reg <= dst_addr_reg;
            end
            wr_en_reg <= ew_en_reg;
            if (ew_en_reg) begin
                wr_addr_reg <= ew_addr_reg;
            end
        end
    end

    assign cmd.cmd_ready = cmd_ready_reg;
    assign rd_en         = rd_en_reg;
    assign rd_addr       = rd_addr_reg;
    assign ew_en         = ew_en_reg;
    assign ew_func       = ew_func_reg;
    assign wr_en         = wr_en_reg;
    assign wr_addr       = wr_addr_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;

endmodule

// File: doc/ewu_sequencer.md
EWU_SEQUENCER -- requirements
Module: ewu_sequencer

Interface
REQ-001 Parameter: ADDR_W, 8, source/destination buffer address width.
REQ-002 Parameter: LEN_W, 8, element-count width (max run 2^LEN_W-1).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_func  input  4  elementwise function code (0001 pass, 0010 ReLU, others are zeroing).
REQ-008 cmd_src  input  ADDR_W  first source (accumulator buffer) address.
REQ-009 cmd_dst  input  ADDR_W  first destination (output buffer) address.
REQ-010 cmd_len  input  LEN_W  element count.
REQ-011 rd_en / rd_addr  output  1 / ADDR_W  source buffer read strobe/address; data returns exactly 1 cycle later.
REQ-012 ew_en / ew_func  output  1 / 4  drive the elementwise unit; its result is registered 1 cycle after ew_en.
REQ-013 wr_en / wr_addr  output  1 / ADDR_W  destination buffer write strobe/address, aligned with elementwise unit output.
REQ-014 busy  output  1  command in progress; done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; handshake occurs when cmd_valid && cmd_ready on a clock edge.
REQ-017 On handshake, func/src/dst/len SHALL be latched; later cmd_* changes have no effect on the run.
REQ-018 Handshake with cmd_len==0: next state DONE, no rd_en/ew_en/wr_en pulses.
REQ-019 Handshake with cmd_len>0: next state ISSUE.
REQ-020 In ISSUE, rd_en=1 every cycle with rd_addr = src+k, k=0..len-1, one address per cycle, no gaps.
REQ-021 ew_en SHALL equal rd_en delayed 1 cycle; ew_func SHALL hold latched func whenever ew_en=1, and 0000 otherwise.
REQ-022 wr_en SHALL equal ew_en delayed 1 cycle; wr_addr = dst+k for the same k; total pipeline latency rd_en→wr_en = 2 cycles.
REQ-023 Address arithmetic modulo 2^ADDR_W (src/dst wrap 255→0 at default).
REQ-024 After the last read issues, ISSUE→DRAIN; DRAIN lasts 2 cycles until the last wr_en; then →DONE.
REQ-025 DONE lasts 1 cycle with done=1, then →IDLE; first handshake accepted the cycle after DONE.
REQ-026 busy=1 in ISSUE, DRAIN, DONE; 0 in IDLE.
REQ-027 Exactly len wr_en pulses per command; wr_en never asserted outside a run.
REQ-028 Element counter LEN_W bits; no overflow at len = 2^LEN_W-1.

Reset
REQ-029 Reset asserted: state IDLE, all counters/latched fields 0, outputs rd_en=ew_en=wr_en=done=busy=0, rd_addr=wr_addr=0, ew_func=0000, cmd_ready=0 while reset high.
REQ-030 Reset asserted mid-run aborts immediately; no pipelined wr_en emerges after release; cmd_ready=1 first cycle after release.

Structure
REQ-031 Function codes (PASS=0001, RELU=0010) and FSM state enum SHALL live in shared package tpu_pkg, also used by the elementwise unit.
REQ-032 Single module, no sub-modules; 2-stage valid/address delay line held in registers.

Verification
REQ-033 Reset release, cmd func=0010 src=0x10 dst=0x40 len=4 → rd_addr 0x10..0x13 consecutive; wr_en 4 pulses at 0x40..0x43, first 2 cycles after first rd_en; done 1 cycle after last wr_en.
REQ-034 len=0 handshake → no rd/ew/wr pulse; done pulse 1 cycle after handshake; busy high 1 cycle.
REQ-035 src=0xFE dst=0xFF len=3 → rd_addr FE,FF,00; wr_addr FF,00,01.
REQ-036 cmd_valid held high continuously with two commands → second accepted only the cycle after done; cmd_ready=0 throughout first run.
REQ-037 Reset asserted 1 cycle into a len=8 run → all outputs 0 immediately, zero wr_en after release, new command accepted normally.
REQ-038 len=255 func=0001 → 255 wr_en pulses contiguous, ew_func=0001 on every ew_en cycle, single done.
